uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLK_MHZ, 12, system clock frequency in MHz.
REQ-002 Parameter: BAUD, 115200, line bit rate.
REQ-003 Parameter: FIFO_DEPTH, 4, receive buffer entries; power of two, minimum 2.
REQ-004 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: rx  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-007 Port: recvData  output  8  byte at FIFO head; valid only while recvValid is high.
REQ-008 Port: recvValid  output  1  FIFO not empty.
REQ-009 Port: recvAck  input  1  pops the head byte when sampled high with recvValid high.
REQ-010 Port: frameErr  output  1  sticky flag: a stop bit was sampled low.
REQ-011 Port: overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-012 Port: errClr  input  1  one-cycle pulse that clears frameErr and overrun.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer, and the FSM SHALL use only the synchronized value.
REQ-014 CLKS_PER_BIT = (CLK_MHZ*1000000)/BAUD, integer-truncated (104 at the defaults); the bit counter SHALL wrap at CLKS_PER_BIT-1.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: a synchronized falling edge (high to low) SHALL move to START and load the counter.
REQ-017 START: at CLKS_PER_BIT/2 clocks, a low line SHALL move to DATA; a high line is a false start and SHALL return to IDLE with no flag set.
REQ-018 DATA: sample every CLKS_PER_BIT clocks from the start mid-point; shift LSB first; after 8 samples move to STOP.
REQ-019 STOP, sample high: push the byte to the FIFO, then go to IDLE.
REQ-020 STOP, sample low: discard the byte, set frameErr, go to WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until the synchronized line is high, then go to IDLE (break tolerance).
REQ-022 Latency: recvValid SHALL rise on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-023 FIFO SHALL be first-word-fall-through: recvData equals the head entry combinationally from registers.
REQ-024 Push while full with no pop: drop the byte and set overrun; FIFO contents are unchanged.
REQ-025 Push and pop in the same cycle, including when full: both SHALL be performed and the count SHALL be unchanged.
REQ-026 recvAck while empty SHALL be ignored.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 errClr coincident with a new error event: the set SHALL win, so the flag stays 1.

Reset
REQ-029 Asserting reset SHALL immediately set FSM=IDLE, both synchronizer flops=1, counters=0, pointers and count=0, recvValid=0, frameErr=0, overrun=0, recvData=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no push and no flag set. After release, a line still low SHALL NOT be taken as a start until it goes high and then low again.

Structure
REQ-031 Shared package uart_pkg SHALL hold: the FSM state encoding, the CLKS_PER_BIT computation, and the 8N1 frame constants (data bits = 8, stop bits = 1). The existing transmitter SHALL reuse the package.
REQ-032 The FIFO SHALL be a separate sub-module, uart_rx_fifo, parameterised by FIFO_DEPTH and width 8.
REQ-033 Target size is 120-400 lines of RTL in total; no latches and no clock gating.

Verification (defaults; 1 bit = 104 clk)
REQ-034 Send 0xA5 with a valid stop bit -> recvValid rises 1 clk after the stop mid-sample, recvData=0xA5, frameErr=0.
REQ-035 Pulse rx low for 30 clk, then back high -> START aborts at clk 52, FSM returns to IDLE, no push, no flags.
REQ-036 Send 0x3C with the stop bit held low for 3 bit times -> no push, frameErr=1, FSM stays in WAIT_IDLE until rx goes high, then the next byte 0x11 is received correctly.
REQ-037 Send 5 bytes 0x01..0x05 with recvAck=0 -> entries 0x01..0x04 are held, 0x05 is dropped, overrun=1; four acks then return 0x01..0x04 in order and recvValid=0.
REQ-038 With the FIFO full, assert recvAck on the same cycle the stop bit of 0x77 is sampled -> count stays 4, overrun stays 0, 0x77 is the last entry.
REQ-039 Assert reset at data bit 4 of 0xFF, then errClr concurrently with a new frame error -> no byte is pushed, and frameErr=1 after the errClr cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and bit-period math.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Truncating divide: the bit period rounds down to whole clocks.
  function automatic int clks_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer; head entry is driven straight from registers.
// A push into a full buffer is performed only if a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, do_push, do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && (!full || do_pop);
  assign drop      = push && full && !do_pop;
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, FIFO and sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_MHZ    = 12,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] recvData,
  output logic       recvValid,
  input  logic       recvAck,
  output logic       frameErr,
  output logic       overrun,
  input  logic       errClr
);

  localparam int CPB  = clks_per_bit(CLK_MHZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS);

  uart_state_e    state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [BW-1:0]  bit_idx, bit_nxt;
  logic [7:0]     shreg, sh_nxt;
  logic           rx_s1, rx_s2, rx_prev;
  logic [1:0]     settle;
  logic           fall, push, frame_set, drop;

  // The synchronizer presets to idle-high, so edges are ignored until both
  // flops hold real line samples; a line held low across reset needs a fresh high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      settle  <= '0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      settle  <= {settle[0], 1'b1};
      rx_prev <= settle[1] & rx_s2;
    end
  end

  assign fall = settle[1] & rx_prev & ~rx_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s2, shreg[7:1]};
          bit_nxt = bit_idx + 1'b1;
          if (bit_idx == BW'(DATA_BITS - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wdata     (shreg),
    .pop       (recvAck),
    .rdata     (recvData),
    .not_empty (recvValid),
    .drop      (drop)
  );

  // A new error event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (frame_set)   frameErr <= 1'b1;
      else if (errClr) frameErr <= 1'b0;
      if (drop)        overrun  <= 1'b1;
      else if (errClr) overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at defaults (104 clocks per bit, 4-entry buffer).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] recvData;
  logic       recvValid;
  logic       recvAck = 1'b0;
  logic       frameErr;
  logic       overrun;
  logic       errClr = 1'b0;

  int vec  = 0;
  int errs = 0;

  localparam int BT = 104;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .recvData  (recvData),
    .recvValid (recvValid),
    .recvAck   (recvAck),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .errClr    (errClr)
  );

  // Drives one frame starting at the next falling edge. stop_len low bit times
  // replace the stop bit (0 = valid stop). ack_cyc/clr_cyc pulse recvAck/errClr
  // so they are sampled on the edge after that cycle; -1 disables. rise_cyc is
  // the first cycle index where recvValid is seen rising.
  task automatic send_frame(input logic [7:0] data, input int stop_len,
                            input int ack_cyc, input int clr_cyc,
                            output int rise_cyc);
    int k;
    logic pv;
    rise_cyc = -1;
    @(negedge clk);
    pv = recvValid;
    rx = 1'b0;
    for (int i = 1; i <= BT * (10 + stop_len); i++) begin
      @(negedge clk);
      if (rise_cyc < 0 && recvValid && !pv) rise_cyc = i;
      pv      = recvValid;
      recvAck = (i == ack_cyc);
      errClr  = (i == clr_cyc);
      if (i % BT == 0) begin
        k = i / BT;
        if (k <= 8)               rx = data[k-1];
        else if (k < 9 + stop_len) rx = 1'b0;
        else                       rx = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", recvValid); end
    vec++; if (recvData !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", recvData); end
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL reset_frameErr got=%b exp=0", frameErr); end
    vec++; if (overrun !== 1'b0)   begin errs++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic;
    int rc;
    send_frame(8'hA5, 0, -1, -1, rc);
    vec++; if (rc !== 991)         begin errs++; $display("FAIL basic_latency got=%0d exp=991", rc); end
    vec++; if (recvValid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", recvValid); end
    vec++; if (recvData !== 8'hA5) begin errs++; $display("FAIL basic_data got=%h exp=a5", recvData); end
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL basic_frameErr got=%b exp=0", frameErr); end
    recvAck = 1'b1; @(negedge clk); recvAck = 1'b0;
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL basic_pop_empty got=%b exp=0", recvValid); end
  endtask

  task automatic test_false_start;
    int rc;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL false_start_push got=%b exp=0", recvValid); end
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL false_start_frameErr got=%b exp=0", frameErr); end
    vec++; if (overrun !== 1'b0)   begin errs++; $display("FAIL false_start_overrun got=%b exp=0", overrun); end
    send_frame(8'h5A, 0, -1, -1, rc);
    vec++; if (recvData !== 8'h5A || recvValid !== 1'b1) begin errs++; $display("FAIL false_start_next got=%h/%b exp=5a/1", recvData, recvValid); end
    recvAck = 1'b1; @(negedge clk); recvAck = 1'b0;
  endtask

  task automatic test_frame_err;
    int rc;
    send_frame(8'h3C, 3, -1, -1, rc);
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL ferr_push got=%b exp=0", recvValid); end
    vec++; if (frameErr !== 1'b1)  begin errs++; $display("FAIL ferr_flag got=%b exp=1", frameErr); end
    send_frame(8'h11, 0, -1, -1, rc);
    vec++; if (recvValid !== 1'b1) begin errs++; $display("FAIL ferr_next_valid got=%b exp=1", recvValid); end
    vec++; if (recvData !== 8'h11) begin errs++; $display("FAIL ferr_next_data got=%h exp=11", recvData); end
    recvAck = 1'b1; errClr = 1'b1; @(negedge clk); recvAck = 1'b0; errClr = 1'b0;
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL ferr_clear got=%b exp=0", frameErr); end
  endtask

  task automatic test_ack_empty;
    int rc;
    recvAck = 1'b1; repeat (3) @(negedge clk); recvAck = 1'b0;
    send_frame(8'hC3, 0, -1, -1, rc);
    vec++; if (recvData !== 8'hC3 || recvValid !== 1'b1) begin errs++; $display("FAIL ack_empty got=%h/%b exp=c3/1", recvData, recvValid); end
    recvAck = 1'b1; @(negedge clk); recvAck = 1'b0;
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL ack_empty_count got=%b exp=0", recvValid); end
  endtask

  task automatic test_overrun;
    int rc;
    logic [7:0] b;
    for (int n = 1; n <= 5; n++) begin
      b = 8'(n);
      send_frame(b, 0, -1, -1, rc);
    end
    vec++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    for (int n = 1; n <= 4; n++) begin
      vec++;
      if (recvValid !== 1'b1 || recvData !== 8'(n)) begin
        errs++; $display("FAIL ovr_pop%0d got=%h/%b exp=%h/1", n, recvData, recvValid, 8'(n));
      end
      recvAck = 1'b1; @(negedge clk); recvAck = 1'b0;
    end
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL ovr_empty got=%b exp=0", recvValid); end
    errClr = 1'b1; @(negedge clk); errClr = 1'b0;
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_full_push_pop;
    int rc;
    logic [7:0] exp_q [4];
    for (int n = 0; n < 4; n++) send_frame(8'h10 + 8'(n), 0, -1, -1, rc);
    send_frame(8'h77, 0, 990, -1, rc);
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL full_pp_overrun got=%b exp=0", overrun); end
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
    for (int n = 0; n < 4; n++) begin
      vec++;
      if (recvValid !== 1'b1 || recvData !== exp_q[n]) begin
        errs++; $display("FAIL full_pp_pop%0d got=%h/%b exp=%h/1", n, recvData, recvValid, exp_q[n]);
      end
      recvAck = 1'b1; @(negedge clk); recvAck = 1'b0;
    end
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL full_pp_count got=%b exp=0", recvValid); end
  endtask

  task automatic test_reset_midframe;
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat (BT * 4 + 50) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (recvValid !== 1'b0 || frameErr !== 1'b0) begin errs++; $display("FAIL rst_mid_during got=%b/%b exp=0/0", recvValid, frameErr); end
    reset = 1'b0;
    repeat (BT * 12) @(negedge clk);
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL rst_mid_push got=%b exp=0", recvValid); end
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL rst_mid_frameErr got=%b exp=0", frameErr); end
    // Line held low across reset must not be taken as a start.
    rx = 1'b0;
    reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0;
    repeat (300) @(negedge clk);
    rx = 1'b1;
    repeat (BT * 12) @(negedge clk);
    vec++; if (recvValid !== 1'b0 || frameErr !== 1'b0) begin errs++; $display("FAIL rst_low_start got=%b/%b exp=0/0", recvValid, frameErr); end
  endtask

  task automatic test_clr_vs_set;
    int rc;
    send_frame(8'hFF, 1, -1, 990, rc);
    vec++; if (frameErr !== 1'b1)  begin errs++; $display("FAIL clr_vs_set got=%b exp=1", frameErr); end
    vec++; if (recvValid !== 1'b0) begin errs++; $display("FAIL clr_vs_set_push got=%b exp=0", recvValid); end
    errClr = 1'b1; @(negedge clk); errClr = 1'b0;
    vec++; if (frameErr !== 1'b0)  begin errs++; $display("FAIL clr_after got=%b exp=0", frameErr); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_frame_err;
    test_ack_empty;
    test_overrun;
    test_full_push_pop;
    test_reset_midframe;
    test_clr_vs_set;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
